// File: rtl/sprite_arb_pkg.sv
// Shared defaults and priority-state encoding for the sprite write arbiter.
package sprite_arb_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    PRI_CPU = 1'b0,
    PRI_LD  = 1'b1
  } pri_state_t;

endpackage

// File: rtl/write_fifo.sv
// Small synchronous FIFO buffering fire-and-forget CPU writes; DEPTH must be a power of two.
module write_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sprite_write_arbiter.sv
// Arbitrates buffered CPU writes against a loader stream into sprite RAM during blanking.
// Define SPRITE_ARB_OVF_COUNT_EN to add the saturating ovf_count port.
module sprite_write_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_full,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              blank,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
`ifdef SPRITE_ARB_OVF_COUNT_EN
  output logic [7:0]        ovf_count,
`endif
  output logic              overflow
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  pri_state_t         state;
  pri_state_t         state_next;
  logic               push;
  logic               cpu_grant;
  logic               ld_grant;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;

  assign push      = cpu_write && !reset;
  assign drop      = push && fifo_full && !cpu_grant;
  assign cpu_full  = (fifo_count == CNT_FULL);
  assign head_addr = fifo_head[ENTRY_W-1:DATA_W];
  assign head_data = fifo_head[DATA_W-1:0];

  write_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (cpu_grant),
    .wdata ({cpu_addr, cpu_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ld_ready is the loader grant condition without ld_valid, so a handshake always means a grant.
  assign ld_ready = !reset && blank && (fifo_empty || state == PRI_LD);

  always_comb begin
    cpu_grant  = 1'b0;
    ld_grant   = 1'b0;
    state_next = state;
    if (!reset && blank) begin
      if (!fifo_empty && (!ld_valid || state == PRI_CPU)) begin
        cpu_grant  = 1'b1;
        state_next = PRI_LD;
      end else if (ld_valid) begin
        ld_grant   = 1'b1;
        state_next = PRI_CPU;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= PRI_CPU;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      overflow <= 1'b0;
    end else begin
      mem_we   <= cpu_grant || ld_grant;
      overflow <= drop;
      if (cpu_grant) begin
        mem_addr <= head_addr;
        mem_data <= head_data;
      end else if (ld_grant) begin
        mem_addr <= ld_addr;
        mem_data <= ld_data;
      end
    end
  end

`ifdef SPRITE_ARB_OVF_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset) ovf_count <= '0;
    else if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sprite_write_arbiter.sv
// Self-checking bench for sprite_write_arbiter: vector table, corner sequences, random run vs queue model.
module tb_sprite_write_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int NVEC  = 15;

  logic          clock;
  logic          reset;
  logic          cpu_write;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_full;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          blank;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          overflow;
`ifdef SPRITE_ARB_OVF_COUNT_EN
  logic [7:0]    ovf_count;
`endif

  sprite_write_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_full  (cpu_full),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .blank     (blank),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
`ifdef SPRITE_ARB_OVF_COUNT_EN
    .ovf_count (ovf_count),
`endif
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: CPU buffer as a queue plus a "loader goes next" flag.
  logic [31:0] cpu_q[$];
  bit          prefer_ld;
  bit          exp_we;
  logic [15:0] exp_addr;
  logic [15:0] exp_data;
  bit          exp_ovf;
  int          exp_ovf_cnt;
  bit          m_ld_grant;
  bit          seen_ready;
  logic [31:0] wr_log[$];

  typedef struct {
    bit          bl;
    bit          cw;
    logic [15:0] ca;
    logic [15:0] cd;
    bit          lv;
    logic [15:0] la;
    logic [15:0] ldd;
    bit          e_ready;
    bit          e_we;
    logic [15:0] e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t vecs[NVEC];

  function automatic vec_t mk(bit bl, bit cw, logic [15:0] ca, logic [15:0] cd, bit lv,
                              logic [15:0] la, logic [15:0] ldd, bit er, bit ew,
                              logic [15:0] ea, logic [15:0] ed);
    vec_t v;
    v.bl = bl; v.cw = cw; v.ca = ca; v.cd = cd; v.lv = lv; v.la = la; v.ldd = ldd;
    v.e_ready = er; v.e_we = ew; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic modelStep(input bit rst, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                           input bit lv, input logic [15:0] la, input logic [15:0] ldd, input bit bl);
    int          sz;
    bit          g_cpu;
    bit          g_ld;
    logic [31:0] head;
    if (rst) begin
      cpu_q.delete();
      prefer_ld   = 1'b0;
      exp_we      = 1'b0;
      exp_addr    = '0;
      exp_data    = '0;
      exp_ovf     = 1'b0;
      exp_ovf_cnt = 0;
      m_ld_grant  = 1'b0;
      return;
    end
    sz         = cpu_q.size();
    g_cpu      = bl && sz > 0 && (!lv || !prefer_ld);
    g_ld       = bl && lv && !g_cpu;
    m_ld_grant = g_ld;
    exp_we     = g_cpu || g_ld;
    if (g_cpu) begin
      head      = cpu_q.pop_front();
      exp_addr  = head[31:16];
      exp_data  = head[15:0];
      prefer_ld = 1'b1;
    end else if (g_ld) begin
      exp_addr  = la;
      exp_data  = ldd;
      prefer_ld = 1'b0;
    end
    exp_ovf = 1'b0;
    if (cw) begin
      if (sz < DEPTH || g_cpu) cpu_q.push_back({ca, cd});
      else begin
        exp_ovf = 1'b1;
        if (exp_ovf_cnt < 255) exp_ovf_cnt++;
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                               input bit lv, input logic [15:0] la, input logic [15:0] ldd, input bit bl);
    reset = rst; cpu_write = cw; cpu_addr = ca; cpu_data = cd;
    ld_valid = lv; ld_addr = la; ld_data = ldd; blank = bl;
    #1;
    seen_ready = ld_ready;
    checkOutput("ld_ready", 32'(ld_ready), 32'(!rst && bl && (cpu_q.size() == 0 || prefer_ld)));
    if (!rst) checkOutput("cpu_full_pre", 32'(cpu_full), 32'(cpu_q.size() == DEPTH));
    @(posedge clock);
    modelStep(rst, cw, ca, cd, lv, la, ldd, bl);
    #1;
    checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
    checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
    checkOutput("mem_data", 32'(mem_data), 32'(exp_data));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("cpu_full_post", 32'(cpu_full), 32'(cpu_q.size() == DEPTH));
`ifdef SPRITE_ARB_OVF_COUNT_EN
    checkOutput("ovf_count", 32'(ovf_count), 32'(exp_ovf_cnt));
`endif
    if (mem_we === 1'b1) wr_log.push_back({mem_addr, mem_data});
  endtask

  task automatic idle(input bit bl, input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, '0, '0, 0, '0, '0, bl);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, '0, '0, 0, '0, '0, 0);
    wr_log.delete();
  endtask

  function automatic logic [31:0] logAt(int i);
    return (wr_log.size() > i) ? wr_log[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          ovf_pulses;
    int          ld_idx;
    bit          r_lv;
    logic [15:0] r_la;
    logic [15:0] r_ld;
    logic [15:0] exp_seq3[5];

    // Single CPU write at cycle 5 lands at cycle 7, then blank 1,0,1 with a loader item.
    vecs[0]  = mk(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = vecs[0];
    vecs[4]  = vecs[0];
    vecs[5]  = mk(1, 1, 16'h0010, 16'h00AB, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    vecs[6]  = mk(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'h0010, 16'h00AB);
    vecs[7]  = mk(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h0010, 16'h00AB);
    vecs[8]  = vecs[7];
    vecs[9]  = vecs[7];
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0200, 16'h1234, 0, 0, 16'h0010, 16'h00AB);
    vecs[11] = vecs[10];
    vecs[12] = mk(1, 0, 16'h0000, 16'h0000, 1, 16'h0200, 16'h1234, 1, 1, 16'h0200, 16'h1234);
    vecs[13] = mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0200, 16'h1234);
    vecs[14] = mk(1, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h1234);

    doReset();
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(0, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].lv, vecs[i].la, vecs[i].ldd, vecs[i].bl);
      checkOutput($sformatf("tbl_ready[%0d]", i), 32'(seen_ready), 32'(vecs[i].e_ready));
      checkOutput($sformatf("tbl_we[%0d]", i), 32'(mem_we), 32'(vecs[i].e_we));
      checkOutput($sformatf("tbl_addr[%0d]", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      checkOutput($sformatf("tbl_data[%0d]", i), 32'(mem_data), 32'(vecs[i].e_data));
    end
    checkOutput("tbl_write_count", 32'(wr_log.size()), 32'd2);

    // Six writes while blanked off: two drops, then four ordered writes.
    doReset();
    ovf_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 16'(32'h0100 + i), 16'(32'h00A0 + i), 0, '0, '0, 0);
      if (overflow === 1'b1) ovf_pulses++;
      if (i == 3) checkOutput("s2_full_after4", 32'(cpu_full), 32'd1);
    end
    checkOutput("s2_ovf_pulses", 32'(ovf_pulses), 32'd2);
`ifdef SPRITE_ARB_OVF_COUNT_EN
    checkOutput("s2_ovf_count", 32'(ovf_count), 32'd2);
`endif
    idle(1, 6);
    checkOutput("s2_write_count", 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("s2_order[%0d]", i), logAt(i), {16'(32'h0100 + i), 16'(32'h00A0 + i)});

    // Two queued CPU entries against three loader items: CPU,LD,CPU,LD,LD.
    doReset();
    applyStimulus(0, 1, 16'h0300, 16'h03A0, 0, '0, '0, 0);
    applyStimulus(0, 1, 16'h0301, 16'h03A1, 0, '0, '0, 0);
    wr_log.delete();
    ld_idx = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 0, '0, '0, ld_idx < 3, 16'(32'h0400 + ld_idx), 16'(32'h04B0 + ld_idx), 1);
      if (m_ld_grant) ld_idx++;
    end
    exp_seq3[0] = 16'h0300; exp_seq3[1] = 16'h0400; exp_seq3[2] = 16'h0301;
    exp_seq3[3] = 16'h0401; exp_seq3[4] = 16'h0402;
    checkOutput("s3_write_count", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ent;
      ent = logAt(i);
      checkOutput($sformatf("s3_seq[%0d]", i), 32'(ent[31:16]), 32'(exp_seq3[i]));
    end

    // Full FIFO taking a write in the cycle its head drains.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 16'(32'h0600 + i), 16'(32'h06F0 + i), 0, '0, '0, 0);
    checkOutput("s4_full", 32'(cpu_full), 32'd1);
    applyStimulus(0, 1, 16'h0604, 16'h06F4, 0, '0, '0, 1);
    checkOutput("s4_no_ovf", 32'(overflow), 32'd0);
    checkOutput("s4_still_full", 32'(cpu_full), 32'd1);
    idle(1, 6);
    checkOutput("s4_write_count", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("s4_order[%0d]", i), logAt(i), {16'(32'h0600 + i), 16'(32'h06F0 + i)});

    // Reset with three entries queued and a write in flight.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'(32'h0500 + i), 16'(32'h05E0 + i), 0, '0, '0, 0);
    applyStimulus(0, 0, '0, '0, 0, '0, '0, 1);
    checkOutput("s5_inflight", 32'(mem_we), 32'd1);
    applyStimulus(1, 0, '0, '0, 0, '0, '0, 1);
    checkOutput("s5_reset_ready", 32'(seen_ready), 32'd0);
    checkOutput("s5_we_cleared", 32'(mem_we), 32'd0);
    checkOutput("s5_addr_cleared", 32'(mem_addr), 32'd0);
    wr_log.delete();
    idle(1, 5);
    checkOutput("s5_empty_ready", 32'(seen_ready), 32'd1);
    checkOutput("s5_no_stale_writes", 32'(wr_log.size()), 32'd0);
    applyStimulus(0, 1, 16'h05F0, 16'h05F5, 1, 16'h0700, 16'h0777, 0);
    applyStimulus(0, 0, '0, '0, 1, 16'h0700, 16'h0777, 1);
    checkOutput("s5_cpu_first_ready", 32'(seen_ready), 32'd0);
    checkOutput("s5_cpu_first_addr", 32'(mem_addr), 32'h05F0);

    // Randomised traffic against the queue model.
    doReset();
    r_lv = 1'b0; r_la = '0; r_ld = '0;
    for (int c = 0; c < 600; c++) begin
      if (!r_lv && $urandom_range(0, 2) == 0) begin
        r_lv = 1'b1;
        r_la = 16'($urandom);
        r_ld = 16'($urandom);
      end
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 45,
                    16'($urandom), 16'($urandom), r_lv, r_la, r_ld,
                    $urandom_range(0, 99) < 65);
      if (m_ld_grant) r_lv = 1'b0;
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/sprite_write_arbiter.md
SPRITE_WRITE_ARBITER -- requirements
Module: sprite_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 16, write address width.
- DATA_W, 16, write data width.
- FIFO_DEPTH, 4, CPU write buffer entries; power of two, >= 2.
REQ-002 Ports SHALL be, one per line:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_write  in  1  stack-machine write strobe; fire-and-forget, no backpressure.
- cpu_addr  in  ADDR_W  stack-machine write address.
- cpu_data  in  DATA_W  stack-machine write data.
- cpu_full  out  1  CPU FIFO holds FIFO_DEPTH entries.
- ld_valid  in  1  loader request valid.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  DATA_W  loader data.
- ld_ready  out  1  loader transfer accepted this cycle when high with ld_valid.
- blank  in  1  video blanking; memory writes permitted only when high.
- mem_we  out  1  registered sprite-RAM write enable.
- mem_addr  out  ADDR_W  registered sprite-RAM address.
- mem_data  out  DATA_W  registered sprite-RAM data.
- overflow  out  1  one-cycle pulse: CPU write dropped.
- ovf_count  out  8  dropped-write count; present only with macro (REQ-019).

Function
REQ-003 cpu_write=1 SHALL enqueue {cpu_addr,cpu_data} into the CPU FIFO unless full with no same-cycle dequeue.
REQ-004 A cpu_write on a full FIFO with no same-cycle dequeue SHALL be dropped and overflow SHALL pulse high the following cycle.
REQ-005 Full FIFO with a same-cycle dequeue SHALL accept the new write; count unchanged.
REQ-006 Priority SHALL be a 2-state FSM: PRI_CPU, PRI_LD; it changes only on a grant.
REQ-007 Grant each cycle, only when blank=1: CPU if FIFO non-empty and (ld_valid=0 or state=PRI_CPU); else loader if ld_valid=1; else none.
REQ-008 After a CPU grant, state SHALL become PRI_LD; after a loader grant, PRI_CPU.
REQ-009 ld_ready SHALL equal blank & (fifo_empty | state==PRI_LD), and SHALL NOT depend on ld_valid.
REQ-010 A grant in cycle n SHALL drive mem_we=1 with the granted address/data in cycle n+1; mem_we=0 in all other cycles.
REQ-011 mem_addr/mem_data SHALL hold their last values when mem_we=0.
REQ-012 A cpu_write at cycle n into an empty FIFO with blank=1 and no loader contention SHALL produce mem_we at cycle n+2.
REQ-013 blank=0 SHALL block all grants; FIFO contents and loader request SHALL be held unchanged.
REQ-014 At most one memory write SHALL occur per cycle; CPU FIFO order SHALL be preserved.
REQ-015 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy tracked with a log2(FIFO_DEPTH)+1-bit counter.

Reset
REQ-016 reset=1 SHALL, on the next clock edge, empty the FIFO (pending entries discarded), set state PRI_CPU, and clear mem_we, mem_addr, mem_data, overflow and ovf_count to 0.
REQ-017 During reset, cpu_write SHALL be ignored and ld_ready SHALL be 0.
REQ-018 After reset deasserts, the first grant SHALL follow REQ-007 with state PRI_CPU.

Configuration
REQ-019 With SPRITE_ARB_OVF_COUNT_EN defined, ovf_count SHALL increment on each dropped write and saturate at 255.
REQ-020 Without SPRITE_ARB_OVF_COUNT_EN, the ovf_count port and counter SHALL be absent; the overflow pulse SHALL remain.

Structure
REQ-021 Package sprite_arb_pkg SHALL hold the ADDR_W/DATA_W/FIFO_DEPTH defaults and the priority state encoding (PRI_CPU=0, PRI_LD=1).
REQ-022 The CPU buffer SHALL be a sub-module write_fifo (push/pop/full/empty/count); arbitration and the output register SHALL live in sprite_write_arbiter.

Verification
REQ-023 The bench SHALL cover, one line each:
- blank=1, idle loader, one cpu_write addr=0x0010 data=0x00AB at cycle 5 -> mem_we=1, 0x0010/0x00AB at cycle 7 only.
- blank=0, 6 back-to-back cpu_writes (DEPTH 4) -> cpu_full=1 after 4; writes 5,6 dropped with 2 overflow pulses; ovf_count=2 if macro enabled; then blank=1 -> exactly 4 writes, in order.
- FIFO holding 2 entries, ld_valid held with 3 loader items, blank=1 -> mem_we sequence CPU,LD,CPU,LD,LD.
- FIFO full, blank=1, cpu_write on a dequeue cycle -> accepted, no overflow, count stays 4.
- reset asserted with 3 entries queued and a grant in flight -> next cycle mem_we=0, FIFO empty, state PRI_CPU, no queued entry written later.
- blank toggling 1,0,1 with ld_valid=1 -> ld_ready=0 and no mem_we while blank=0; loader item written once.
